// File: rtl/rca4_serial_add_ctrl.sv
// Digit-serial sequencer for a registered 4-bit ripple-carry adder stage.
// Feeds operands one nibble per pass (LSB first) and chains the carry between passes.
module rca4_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   parameter int ADD_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   input  logic                   cin_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum_out,
   output logic                   cout_out,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_s,
   input  logic                   add_cout
);

   localparam int W   = 4 * NIBBLES;
   localparam int IW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int WCW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      DONE
   } state_t;

   state_t         state;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   sum_sh;
   logic           carry;
   logic [IW-1:0]  idx;
   logic [WCW-1:0] wcnt;

   logic [W-1:0]   a_next;
   logic [W-1:0]   b_next;
   logic [W+3:0]   sum_cat;
   logic [W-1:0]   sum_next;

   // The captured nibble enters at the top so after NIBBLES passes the word is aligned.
   always_comb begin
      a_next   = a_sh >> 4;
      b_next   = b_sh >> 4;
      sum_cat  = {add_s, sum_sh};
      sum_next = sum_cat[W+3:4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         sum_sh   <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         wcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum_out  <= '0;
         cout_out <= 1'b0;
         add_a    <= 4'h0;
         add_b    <= 4'h0;
         add_cin  <= 1'b0;
      end else begin
         done    <= 1'b0;
         add_a   <= 4'h0;
         add_b   <= 4'h0;
         add_cin <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a_in;
                  b_sh    <= b_in;
                  carry   <= cin_in;
                  idx     <= '0;
                  sum_sh  <= '0;
                  add_a   <= a_in[3:0];
                  add_b   <= b_in[3:0];
                  add_cin <= cin_in;
                  busy    <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (ADD_LAT == 1) begin
                  state <= CAPTURE;
               end else begin
                  wcnt  <= WCW'(ADD_LAT - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (wcnt == WCW'(1)) begin
                  state <= CAPTURE;
               end else begin
                  wcnt <= wcnt - WCW'(1);
               end
            end
            CAPTURE: begin
               sum_sh <= sum_next;
               carry  <= add_cout;
               a_sh   <= a_next;
               b_sh   <= b_next;
               idx    <= idx + IW'(1);
               // Adder-port registers are loaded here so they are valid throughout ISSUE.
               if (idx == IW'(NIBBLES - 1)) begin
                  sum_out  <= sum_next;
                  cout_out <= add_cout;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  add_a   <= a_next[3:0];
                  add_b   <= b_next[3:0];
                  add_cin <= add_cout;
                  state   <= ISSUE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca4_serial_add_ctrl.sv
// Bench for rca4_serial_add_ctrl: models the registered adder stage and checks
// every cycle against an arithmetic reference, plus literal expectations per directed op.
module tb_rca4_serial_add_ctrl;

   localparam int NIBBLES = 4;
   localparam int ADD_LAT = 2;
   localparam int W       = 4 * NIBBLES;
   localparam int STEP    = ADD_LAT + 1;
   localparam int TOT     = NIBBLES * STEP + 1;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic           cin_in;
   logic           busy;
   logic           done;
   logic [W-1:0]   sum_out;
   logic           cout_out;
   logic [3:0]     add_a;
   logic [3:0]     add_b;
   logic           add_cin;
   logic [3:0]     add_s;
   logic           add_cout;

   int checks;
   int passes;
   int cyc;

   rca4_serial_add_ctrl #(.NIBBLES(NIBBLES), .ADD_LAT(ADD_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_s    (add_s),
      .add_cout (add_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered adder stage: ADD_LAT clocks from operands sampled to sum valid, flushed by rst.
   logic [4:0] pipe [ADD_LAT];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) pipe[i] <= 5'd0;
      end else begin
         pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
         for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign {add_cout, add_s} = pipe[ADD_LAT-1];

   task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act == exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: k counts cycles since the accepting edge; results come from plain addition.
   int                k;
   bit                model_valid;
   longint unsigned   ma, mb, mcin;
   longint unsigned   exp_sum, exp_cout;

   always @(posedge clk) begin
      if (rst) begin
         k           = 0;
         exp_sum     = 0;
         exp_cout    = 0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (k == 0) begin
            if (start) begin
               k    = 1;
               ma   = longint'(a_in);
               mb   = longint'(b_in);
               mcin = longint'(cin_in);
            end
         end else if (k == TOT) begin
            k = 0;
         end else begin
            k++;
            if (k == TOT) begin
               exp_sum  = (ma + mb + mcin) & ((64'd1 << W) - 1);
               exp_cout = ((ma + mb + mcin) >> W) & 64'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      longint unsigned ea, eb, ec, mask;
      int n;
      if (model_valid) begin
         ea = 0;
         eb = 0;
         ec = 0;
         if (k >= 1 && k < TOT && ((k - 1) % STEP) == 0) begin
            n    = (k - 1) / STEP;
            mask = (64'd1 << (4 * n)) - 1;
            ea   = (ma >> (4 * n)) & 64'hF;
            eb   = (mb >> (4 * n)) & 64'hF;
            ec   = ((ma & mask) + (mb & mask) + mcin) >> (4 * n);
         end
         checkOutput("busy", longint'(busy), (k != 0) ? 64'd1 : 64'd0);
         checkOutput("done", longint'(done), (k == TOT) ? 64'd1 : 64'd0);
         checkOutput("sum_out", longint'(sum_out), exp_sum);
         checkOutput("cout_out", longint'(cout_out), exp_cout);
         checkOutput("add_a", longint'(add_a), ea);
         checkOutput("add_b", longint'(add_b), eb);
         checkOutput("add_cin", longint'(add_cin), ec);
      end
   end

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      a_in   = a;
      b_in   = b;
      cin_in = c;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Called at the negedge of cycle 1 after the accepting edge; returns the cycle done was seen in.
   task automatic waitDone(output int lat, output int busy_cycles, output int cin_hits);
      bit seen;
      lat         = 1;
      busy_cycles = 0;
      cin_hits    = 0;
      seen        = 1'b0;
      while (!seen && lat <= 40) begin
         if (busy) busy_cycles++;
         if (busy && add_cin) cin_hits++;
         if (done) begin
            seen = 1'b1;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, bc, ch, dones, d1, d2;
      longint unsigned full;
      logic [W-1:0] ra, rb;
      logic rc;
      checks = 0;
      passes = 0;
      cyc    = 0;
      rst    = 1'b1;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      cin_in = 1'b0;
      model_valid = 1'b0;
      k = 0;
      ma = 0; mb = 0; mcin = 0; exp_sum = 0; exp_cout = 0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", longint'(busy), 64'd0);
      checkOutput("reset done", longint'(done), 64'd0);
      checkOutput("reset sum_out", longint'(sum_out), 64'd0);
      checkOutput("reset add_a", longint'(add_a), 64'd0);
      rst = 1'b0;

      // Test 1: latency and busy window.
      applyStimulus(16'h1234, 16'h4321, 1'b0);
      waitDone(lat, bc, ch);
      checkOutput("t1 latency", longint'(lat), 64'd13);
      checkOutput("t1 busy cycles", longint'(bc), 64'd13);
      checkOutput("t1 sum", longint'(sum_out), 64'h5555);
      checkOutput("t1 cout", longint'(cout_out), 64'd0);
      @(negedge clk);
      checkOutput("t1 busy after", longint'(busy), 64'd0);

      // Test 2: carry rippling through every nibble.
      applyStimulus(16'hFFFF, 16'h0001, 1'b0);
      waitDone(lat, bc, ch);
      checkOutput("t2 sum", longint'(sum_out), 64'h0000);
      checkOutput("t2 cout", longint'(cout_out), 64'd1);
      checkOutput("t2 add_cin hits", longint'(ch), 64'd3);

      // Test 3: carry-in extremes.
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
      waitDone(lat, bc, ch);
      checkOutput("t3a sum", longint'(sum_out), 64'hFFFF);
      checkOutput("t3a cout", longint'(cout_out), 64'd1);
      applyStimulus(16'h0000, 16'h0000, 1'b1);
      waitDone(lat, bc, ch);
      checkOutput("t3b sum", longint'(sum_out), 64'h0001);
      checkOutput("t3b cout", longint'(cout_out), 64'd0);

      // Test 4: start pulses while busy, including during DONE.
      applyStimulus(16'h00AA, 16'h0055, 1'b0);
      dones = 0;
      for (int c = 2; c <= 20; c++) begin
         @(negedge clk);
         if (done) dones++;
         if (c == 4 || c == 13) begin
            a_in  = 16'h1111 * c[15:0];
            b_in  = 16'h2222;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      checkOutput("t4 sum", longint'(sum_out), 64'h00FF);
      checkOutput("t4 cout", longint'(cout_out), 64'd0);
      checkOutput("t4 done pulses", longint'(dones), 64'd1);

      // Test 5: reset mid-operation.
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5 busy", longint'(busy), 64'd0);
      checkOutput("t5 sum", longint'(sum_out), 64'd0);
      rst = 1'b0;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dones++;
      end
      checkOutput("t5 no done", longint'(dones), 64'd0);
      applyStimulus(16'h8000, 16'h8000, 1'b0);
      waitDone(lat, bc, ch);
      checkOutput("t5 sum after", longint'(sum_out), 64'h0000);
      checkOutput("t5 cout after", longint'(cout_out), 64'd1);

      // Test 6: start held high, two back-to-back operations.
      @(negedge clk);
      a_in   = 16'h0102;
      b_in   = 16'h0304;
      cin_in = 1'b0;
      start  = 1'b1;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      d1 = cyc;
      checkOutput("t6 first done", longint'(done), 64'd1);
      checkOutput("t6 first sum", longint'(sum_out), 64'h0406);
      a_in   = 16'h7000;
      b_in   = 16'h9001;
      cin_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("t6 second accepted", longint'(busy), 64'd1);
      waitDone(lat, bc, ch);
      d2 = cyc;
      checkOutput("t6 done spacing", longint'(d2 - d1), 64'd14);
      checkOutput("t6 second sum", longint'(sum_out), 64'h0002);
      checkOutput("t6 second cout", longint'(cout_out), 64'd1);

      // Random regression.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom_range(0, 65535));
         rb = W'($urandom_range(0, 65535));
         rc = 1'($urandom_range(0, 1));
         applyStimulus(ra, rb, rc);
         waitDone(lat, bc, ch);
         full = longint'(ra) + longint'(rb) + longint'(rc);
         checkOutput("rand sum", longint'(sum_out), full & 64'hFFFF);
         checkOutput("rand cout", longint'(cout_out), (full >> 16) & 64'd1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
